// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write port.
//   DW / AW / NREG : register data width, address width, register count
//   IDX_LAST       : last register index, where the bulk clear ends
//   state_e        : clear sequencer states (RUN, DRAIN, CLEAR)
//   wr_req_t       : one queued write request {addr, data}
//   sat_inc8       : saturating 8-bit increment used by the commit counter
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREG = 2 ** AW;

  localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_wq.sv
// -----------------------------------------------------------------------------
// regfile_wq
// Synchronous first-word-fall-through FIFO of write requests.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the queue)
//   push        : enqueue push_data (ignored when full)
//   push_data   : request to enqueue
//   pop         : dequeue the head (ignored when empty)
//   pop_data    : current head of the queue, valid while !empty
//   full, empty : occupancy flags
//   level       : number of queued requests, 0..QDEPTH
// -----------------------------------------------------------------------------
module regfile_wq
  import regfile_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wr_req_t                  push_data,
  input  logic                     pop,
  output wr_req_t                  pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  level
);

  localparam int PW = $clog2(QDEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(QDEPTH);

  wr_req_t         buf_r [QDEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign full      = (level_r == FULL_LEVEL);
  assign empty     = (level_r == {LW{1'b0}});
  assign level     = level_r;
  assign pop_data  = buf_r[rd_ptr_r];

  // Guard the pointers against overflow/underflow requests.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy; pointers wrap naturally since QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        buf_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        buf_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// -----------------------------------------------------------------------------
// regfile_write_port
// Write side of the 16 x 16-bit register file. Write requests are accepted
// over a valid/ready handshake into a small queue; one queued write commits
// into the array per cycle. A clear request drains the queue and then zeroes
// every register, one per cycle. R0 always reads zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_valid    : write request valid
//   wr_ready    : a write can be accepted this cycle
//   wr_addr     : target register
//   wr_data     : write data
//   clr_req     : one-cycle pulse requesting a bulk clear
//   clr_busy    : clear sequence in progress (DRAIN or CLEAR)
//   n1, rd1     : asynchronous read port, rd1 = mem[n1]
//   q_level     : current queue occupancy
//   wr_count    : committed writes to R1..R15, saturating at 255
// -----------------------------------------------------------------------------
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [AW-1:0]            n1,
  output logic [DW-1:0]            rd1,
  output logic [$clog2(QDEPTH):0]  q_level,
  output logic [7:0]               wr_count
);

  state_e                  state_r;
  logic                    clr_busy_r;
  logic [AW-1:0]           idx_r;
  logic [DW-1:0]           mem_r [NREG];
  logic [7:0]              wr_count_r;

  wr_req_t                 push_req_s;
  wr_req_t                 head_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    empty_s;
  logic                    commit_live_s;
  logic [$clog2(QDEPTH):0] level_s;

  // Acceptance depends only on registered state, so a full queue blocks a
  // push even when a pop happens on the same edge.
  assign wr_ready   = (state_r == RUN) && !full_s;
  assign push_s     = wr_valid && wr_ready;
  assign push_req_s = '{addr: wr_addr, data: wr_data};

  // The head commits every cycle outside CLEAR; DRAIN keeps committing so
  // writes accepted before the clear land before being zeroed.
  assign pop_s         = !empty_s && (state_r != CLEAR);
  // Writes to R0 are popped but dropped.
  assign commit_live_s = pop_s && (head_s.addr != {AW{1'b0}});

  assign clr_busy = clr_busy_r;
  assign q_level  = level_s;
  assign wr_count = wr_count_r;
  assign rd1      = mem_r[n1];

  regfile_wq #(
    .QDEPTH (QDEPTH)
  ) u_wq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_req_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  // Clear sequencer: RUN -> DRAIN on clr_req, DRAIN -> CLEAR once empty, CLEAR walks idx 0..15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      clr_busy_r <= 1'b0;
      idx_r      <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (clr_req) begin
            state_r    <= DRAIN;
            clr_busy_r <= 1'b1;
          end else begin
            state_r    <= RUN;
            clr_busy_r <= 1'b0;
          end
        end
        DRAIN: begin
          // clr_req is ignored here; empty_s is sampled before this edge's pop.
          if (empty_s) begin
            state_r <= CLEAR;
            idx_r   <= '0;
          end else begin
            state_r <= DRAIN;
          end
          clr_busy_r <= 1'b1;
        end
        CLEAR: begin
          idx_r <= idx_r + 1'b1;
          if (idx_r == IDX_LAST) begin
            state_r    <= RUN;
            clr_busy_r <= 1'b0;
          end else begin
            state_r    <= CLEAR;
            clr_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= RUN;
          clr_busy_r <= 1'b0;
          idx_r      <= '0;
        end
      endcase
    end
  end

  // Register array: CLEAR zeroes one entry per cycle, otherwise the queue head commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= '0;
      end
    end else if (state_r == CLEAR) begin
      mem_r[idx_r] <= '0;
    end else if (commit_live_s) begin
      mem_r[head_s.addr] <= head_s.data;
    end
  end

  // Commit counter for R1..R15; the clear sequence does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_r <= 8'd0;
    end else if (commit_live_s) begin
      wr_count_r <= sat_inc8(wr_count_r);
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

endmodule
